// File: rtl/vproc_instr_queue.sv
// -----------------------------------------------------------------------------
// vproc_instr_queue
//
// Instruction queue sitting between the vector decoder and the dispatcher.
// Holds up to DEPTH decoded instructions, each with the map of vector
// registers it writes. The oldest entry is presented first-word-fall-through.
// The OR of the write maps of all buffered entries is exported so the decoder
// can detect hazards against instructions that have not been dispatched yet.
//
// Ports:
//   clk_i                clock
//   async_rst_ni         asynchronous active-low reset
//   flush_i              synchronous flush; empties the queue
//   instr_valid_i        decoder offers an instruction
//   instr_ready_o        queue can accept an instruction (not full)
//   instr_data_i         decoder payload
//   instr_vreg_wr_i      vregs written by the offered instruction
//   instr_valid_o        head entry valid toward the dispatcher
//   instr_ready_i        dispatcher consumes the head entry
//   instr_data_o         head payload
//   instr_vreg_wr_o      head write map
//   queue_vreg_wr_map_o  OR of write maps of all valid entries
//   fill_cnt_o           number of valid entries
// -----------------------------------------------------------------------------
module vproc_instr_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MAX_VADDR_W    = 5,
  parameter type         DECODER_DATA_T = logic,
  parameter logic        DONT_CARE_ZERO = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          async_rst_ni,
  input  logic                          flush_i,

  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  input  DECODER_DATA_T                 instr_data_i,
  input  logic [(1<<MAX_VADDR_W)-1:0]   instr_vreg_wr_i,

  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output DECODER_DATA_T                 instr_data_o,
  output logic [(1<<MAX_VADDR_W)-1:0]   instr_vreg_wr_o,

  output logic [(1<<MAX_VADDR_W)-1:0]   queue_vreg_wr_map_o,
  output logic [$clog2(DEPTH):0]        fill_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MAP_W = 1 << MAX_VADDR_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push, pop, wr_allow;

  // Flattened views of the per-entry storage
  DECODER_DATA_T    data_all [DEPTH];
  logic [MAP_W-1:0] vreg_all [DEPTH];
  logic [DEPTH-1:0] entry_valid;

  // Handshakes depend on registered state only
  assign instr_ready_o = (count_q != CNT_W'(DEPTH));
  assign instr_valid_o = (count_q != '0);

  assign push = instr_valid_i & instr_ready_o;
  assign pop  = instr_valid_o & instr_ready_i;

  // A push in the flush cycle is discarded, so it must not reach storage
  assign wr_allow = push & ~flush_i;

  // ---------------------------------------------------------------------------
  // Per-entry storage
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    DECODER_DATA_T    data_q;
    logic [MAP_W-1:0] vreg_q;
    logic             wr_en;
    logic [PTR_W-1:0] off;

    assign wr_en = wr_allow && (wr_ptr_q == PTR_W'(gi));

    if (DONT_CARE_ZERO) begin : g_zero
      // Storage is kept at zero whenever it holds nothing meaningful
      always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
          data_q <= '0;
          vreg_q <= '0;
        end else if (flush_i) begin
          data_q <= '0;
          vreg_q <= '0;
        end else if (wr_en) begin
          data_q <= instr_data_i;
          vreg_q <= instr_vreg_wr_i;
        end
      end
    end else begin : g_plain
      always_ff @(posedge clk_i) begin
        if (wr_en) begin
          data_q <= instr_data_i;
          vreg_q <= instr_vreg_wr_i;
        end
      end
    end

    assign data_all[gi] = data_q;
    assign vreg_all[gi] = vreg_q;

    // Entry is live when its distance from the read pointer (mod DEPTH)
    // is below the fill count
    assign off             = PTR_W'(gi) - rd_ptr_q;
    assign entry_valid[gi] = ({1'b0, off} < count_q);
  end

  // ---------------------------------------------------------------------------
  // Pointer and count update
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    if (DONT_CARE_ZERO && (count_q == '0)) begin
      instr_data_o    = '0;
      instr_vreg_wr_o = '0;
    end else begin
      instr_data_o    = data_all[rd_ptr_q];
      instr_vreg_wr_o = vreg_all[rd_ptr_q];
    end
  end

  // Union of registered entries only; an instruction being pushed this cycle
  // is not included
  always_comb begin
    queue_vreg_wr_map_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        queue_vreg_wr_map_o = queue_vreg_wr_map_o | vreg_all[i];
      end
    end
  end

  assign fill_cnt_o = count_q;

endmodule

// File: doc/vproc_instr_queue.md
# vproc_instr_queue

Instruction queue between the vector decoder and the dispatcher. Buffers up to DEPTH decoded instructions together with their vector-register write maps. Presents the oldest entry to the dispatcher with a first-word-fall-through valid/ready handshake. Exports the union of the write maps of all buffered entries so the decoder can check hazards against instructions not yet dispatched.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- MAX_VADDR_W, 5, vreg address width; write maps are (1<<MAX_VADDR_W) bits wide
- DECODER_DATA_T, logic, decoder payload type; stored opaquely
- DONT_CARE_ZERO, 1'b0, drive don't-care outputs and storage to zero

Ports:
- clk_i  in  1  clock; only clock of the block
- async_rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous flush; empties the queue
- instr_valid_i  in  1  decoder offers an instruction
- instr_ready_o  out  1  queue accepts an instruction
- instr_data_i  in  DECODER_DATA_T  decoder payload
- instr_vreg_wr_i  in  1<<MAX_VADDR_W  vregs written by the offered instruction
- instr_valid_o  out  1  head entry valid toward the dispatcher
- instr_ready_i  in  1  dispatcher consumes the head entry
- instr_data_o  out  DECODER_DATA_T  head payload
- instr_vreg_wr_o  out  1<<MAX_VADDR_W  head write map
- queue_vreg_wr_map_o  out  1<<MAX_VADDR_W  OR of write maps of all valid entries
- fill_cnt_o  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage is a circular buffer of DEPTH entries {data, vreg_wr} with a write pointer, a read pointer ($clog2(DEPTH) bits, natural wrap) and a count (0..DEPTH).
- Push: instr_valid_i & instr_ready_o. The entry is written at wr_ptr, then wr_ptr++.
- Pop: instr_valid_o & instr_ready_i. Then rd_ptr++.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- instr_ready_o = (count != DEPTH). This is combinational from state only and does not depend on instr_ready_i: a full queue refuses a push even when a pop happens in the same cycle.
- instr_valid_o = (count != 0). instr_data_o and instr_vreg_wr_o come from the entry at rd_ptr.
  - When empty, with DONT_CARE_ZERO=1 both are driven '0; otherwise they are undefined.
- queue_vreg_wr_map_o is the OR over all entries i that are valid, where "valid" is i within count of rd_ptr, modulo DEPTH.
  - It is combinational from registered state and is '0 when empty.
  - It excludes an instruction being pushed in the current cycle.
- Flush (flush_i=1):
  - Next cycle: count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop in the flush cycle is discarded. Handshake outputs are still driven normally in that cycle.
  - Storage contents are not cleared, except that with DONT_CARE_ZERO=1 they are zeroed.
- No instruction reordering. Entries leave in exact push order.

## Timing
- Reset (async_rst_ni=0), taking effect immediately:
  - count=0, pointers=0.
  - instr_valid_o=0, instr_ready_o=1, fill_cnt_o=0, queue_vreg_wr_map_o='0.
  - instr_data_o/instr_vreg_wr_o='0 if DONT_CARE_ZERO.
- Reset deassertion mid-stream: the queue is empty, and nothing pushed before reset is ever presented.
- Latency: a push in cycle N makes the entry visible on the outputs in cycle N+1 at the earliest. There is no combinational path from input to output data.
- Throughput: with the dispatcher always ready, one push and one pop per cycle is sustained for any count in 1..DEPTH-1.
- Full boundary: at count=DEPTH, instr_ready_o=0. After a pop, instr_ready_o=1 in the following cycle.
- Empty boundary: at count=0, instr_valid_o=0, and a push in that cycle cannot be popped in the same cycle.
- Pointers wrap from DEPTH-1 to 0 with no gap or bubble.
- instr_valid_o must not depend on instr_ready_i. Once asserted, it stays high until popped or flushed. The head data is stable while it is not popped.

## Test plan
- **Reset and empty state:** reset, then idle with instr_valid_i=0 for 3 cycles -> instr_valid_o=0, instr_ready_o=1, fill_cnt_o=0, queue_vreg_wr_map_o=0 throughout.
- **Fill to full, then drain:** DEPTH=4; push maps 0x1, 0x2, 0x4, 0x8 with instr_ready_i=0.
  - After the pushes: fill_cnt_o=4, instr_ready_o=0, queue_vreg_wr_map_o=0xF. A 5th push is refused.
  - Then raise instr_ready_i: outputs are 0x1, 0x2, 0x4, 0x8 in order on consecutive cycles. The map decays 0xE, 0xC, 0x8, 0x0.
- **Streaming with wrap-around:** push 10 entries back-to-back with instr_ready_i=1 -> 10 pops in push order, one per cycle after the first. fill_cnt_o stays at 1. The pointers wrap twice without loss.
- **Full with simultaneous pop:** count=4, instr_valid_i=1, instr_ready_i=1 -> that cycle pops and refuses the push. Next cycle fill_cnt_o=3, instr_ready_o=1, and the push is accepted.
- **Flush:** count=3; assert flush_i together with a push and a pop -> next cycle fill_cnt_o=0, instr_valid_o=0, map=0. A subsequent push of map 0x20 appears at the head one cycle later.
- **Asynchronous reset mid-stream:** count=2; drop async_rst_ni between clock edges -> outputs take their reset values immediately. After release, the queue is empty and the old entries never appear.
